// File: rtl/mem_pkg.sv
// Shared types and address-field helpers for the physical memory / IO bus bridge.
package mem_pkg;
  localparam int WORD_W = 32;
  localparam int ADDR_W = 30;
  localparam int CNT_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } io_state_t;

  // A single slot still gets a 1-bit field; that bit then falls in the reserved gap.
  function automatic int slot_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int gap_lsb(input int slot_depth, input int n);
    return slot_depth + slot_w(n);
  endfunction
endpackage

// File: rtl/phy_mem_io_if.sv
// IO slot bus: one-hot request strobes out, per-slot ack/read data back.
interface phy_mem_io_if
  import mem_pkg::*;
#(
  parameter int IO_SLOTS   = 4,
  parameter int SLOT_DEPTH = 8
);
  logic [IO_SLOTS-1:0]             IO_REQ;
  logic                            IO_WE;
  logic [SLOT_DEPTH-1:0]           IO_ADDR;
  logic [WORD_W-1:0]               IO_WD;
  logic [IO_SLOTS-1:0]             IO_ACK;
  logic [IO_SLOTS-1:0][WORD_W-1:0] IO_RD;

  modport master (output IO_REQ, IO_WE, IO_ADDR, IO_WD, input IO_ACK, IO_RD);
  modport slave  (input IO_REQ, IO_WE, IO_ADDR, IO_WD, output IO_ACK, IO_RD);
endinterface

// File: rtl/ffd.sv
// 1-bit register with synchronous reset and load enable.
module ffd (
  input  logic CLK,
  input  logic RESET,
  input  logic EN,
  input  logic D,
  output logic Q
);
  always_ff @(posedge CLK) begin
    if (RESET)   Q <= 1'b0;
    else if (EN) Q <= D;
  end
endmodule

// File: rtl/io_slot_sel.sv
// Picks the ack bit and read word of the addressed IO slot.
module io_slot_sel #(
  parameter int IO_SLOTS = 4,
  parameter int SLOT_W   = 2
) (
  input  logic [SLOT_W-1:0]         slot,
  input  logic [IO_SLOTS-1:0]       ack,
  input  logic [IO_SLOTS-1:0][31:0] rd,
  output logic                      ack_sel,
  output logic [31:0]               rd_sel
);
  always_comb begin
    ack_sel = 1'b0;
    rd_sel  = '0;
    for (int k = 0; k < IO_SLOTS; k++) begin
      if (slot == SLOT_W'(k)) begin
        ack_sel = ack[k];
        rd_sel  = rd[k];
      end
    end
  end
endmodule

// File: rtl/onchip_ram.sv
// Dual-port word RAM: instruction read port plus byte-writable data port, 1-cycle reads.
module onchip_ram #(
  parameter int ADDR_W = 14
) (
  input  logic              CLK,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [31:0]       i_rd,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic              d_we,
  input  logic [3:0]        d_be,
  input  logic [31:0]       d_wd,
  output logic [31:0]       d_rd
);
  logic [31:0] mem [2**ADDR_W];

  always_ff @(posedge CLK) begin
    for (int b = 0; b < 4; b++)
      if (d_we && d_be[b]) mem[d_addr][8*b +: 8] <= d_wd[8*b +: 8];
    d_rd <= mem[d_addr];
    i_rd <= mem[i_addr];
  end
endmodule

// File: rtl/phy_mem_io.sv
// Core-side memory bridge: on-chip RAM below the IO window, slotted IO bus above it,
// everything else flagged as a bus error.
module phy_mem_io
  import mem_pkg::*;
#(
  parameter int RAM_DEPTH  = 14,
  parameter int IO_SLOTS   = 4,
  parameter int SLOT_DEPTH = 8,
  parameter int TIMEOUT    = 15
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [ADDR_W-1:0] I_ADDR,
  output logic [WORD_W-1:0] I_DATA,
  output logic              I_BERR,
  input  logic [ADDR_W-1:0] D_ADDR,
  input  logic              D_RE,
  input  logic              D_WE,
  input  logic [3:0]        D_BE,
  input  logic [WORD_W-1:0] D_WD,
  input  logic              INHIBIT,
  output logic [WORD_W-1:0] D_RD,
  output logic              D_BERR_A,
  output logic              D_BERR,
  output logic              D_STALL,
  phy_mem_io_if.master      io
);
  localparam int SW      = slot_w(IO_SLOTS);
  localparam int SWP     = SW + 1;
  localparam int GAP_LSB = gap_lsb(SLOT_DEPTH, IO_SLOTS);
  localparam logic [SW:0] NSLOT = SWP'(IO_SLOTS);

  logic                 d_req, hi_rsv, io_rgn, io_bad, ram_hit, io_hit, rsv, ram_we;
  logic [RAM_DEPTH-1:0] low;
  logic [SW-1:0]        slot, slot_q;
  logic [SLOT_DEPTH-1:0] addr_q;
  logic [WORD_W-1:0]    wd_q, cap_q, cap_nx, rd_sel, ram_rd;
  logic [CNT_W-1:0]     cnt;
  logic                 we_q, err_q, err_nx, ack_sel, start, cap_en, stall, io_sel_q;
  io_state_t            state, state_nx;

  assign d_req   = D_RE | D_WE;
  assign hi_rsv  = |D_ADDR[ADDR_W-1:RAM_DEPTH+1];
  assign io_rgn  = D_ADDR[RAM_DEPTH];
  assign low     = D_ADDR[RAM_DEPTH-1:0];
  assign slot    = D_ADDR[SLOT_DEPTH +: SW];
  assign io_bad  = ({1'b0, slot} >= NSLOT) || ((low >> GAP_LSB) != '0);
  assign ram_hit = ~hi_rsv & ~io_rgn;
  assign io_hit  = ~hi_rsv & io_rgn & ~io_bad;
  assign rsv     = hi_rsv | (io_rgn & io_bad);

  assign D_BERR_A = d_req & rsv;
  assign ram_we   = D_WE & ~INHIBIT & ram_hit;

  onchip_ram #(.ADDR_W(RAM_DEPTH)) u_ram (
    .CLK   (CLK),
    .i_addr(I_ADDR[RAM_DEPTH-1:0]),
    .i_rd  (I_DATA),
    .d_addr(low),
    .d_we  (ram_we),
    .d_be  (D_BE),
    .d_wd  (D_WD),
    .d_rd  (ram_rd)
  );

  io_slot_sel #(.IO_SLOTS(IO_SLOTS), .SLOT_W(SW)) u_sel (
    .slot   (slot_q),
    .ack    (io.IO_ACK),
    .rd     (io.IO_RD),
    .ack_sel(ack_sel),
    .rd_sel (rd_sel)
  );

  // Once issued, a transaction runs to DONE regardless of INHIBIT.
  always_comb begin
    state_nx = state;
    start    = 1'b0;
    stall    = 1'b0;
    cap_en   = 1'b0;
    cap_nx   = '0;
    err_nx   = err_q;
    case (state)
      ST_IDLE: if (d_req & io_hit & ~INHIBIT) begin
        start    = 1'b1;
        stall    = 1'b1;
        err_nx   = 1'b0;
        state_nx = ST_WAIT;
      end
      ST_WAIT: begin
        stall = 1'b1;
        if (ack_sel) begin
          cap_en   = 1'b1;
          cap_nx   = we_q ? '0 : rd_sel;
          state_nx = ST_DONE;
        end else if (cnt == CNT_W'(TIMEOUT)) begin
          cap_en   = 1'b1;
          err_nx   = 1'b1;
          state_nx = ST_DONE;
        end
      end
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  assign D_STALL = stall & ~RESET;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= ST_IDLE;
      cnt   <= '0;
      cap_q <= '0;
    end else begin
      state <= state_nx;
      if (start)                cnt <= '0;
      else if (state == ST_WAIT) cnt <= cnt + CNT_W'(1);
      if (cap_en) cap_q <= cap_nx;
    end
  end

  always_ff @(posedge CLK) begin
    if (start) begin
      slot_q <= slot;
      addr_q <= D_ADDR[SLOT_DEPTH-1:0];
      wd_q   <= D_WD;
    end
  end

  ffd u_we    (.CLK(CLK), .RESET(RESET), .EN(start), .D(D_WE),   .Q(we_q));
  ffd u_err   (.CLK(CLK), .RESET(RESET), .EN(1'b1),  .D(err_nx), .Q(err_q));
  ffd u_iosel (.CLK(CLK), .RESET(RESET), .EN(1'b1),  .D(state == ST_DONE), .Q(io_sel_q));
  ffd u_iberr (.CLK(CLK), .RESET(RESET), .EN(1'b1),  .D(|I_ADDR[ADDR_W-1:RAM_DEPTH+1]), .Q(I_BERR));
  ffd u_dberr (.CLK(CLK), .RESET(RESET), .EN(1'b1),
               .D(D_BERR_A | ((state == ST_DONE) & err_q)), .Q(D_BERR));

  assign D_RD = io_sel_q ? cap_q : ram_rd;

  always_comb begin
    io.IO_REQ = '0;
    if (state == ST_WAIT) io.IO_REQ[slot_q] = 1'b1;
  end
  assign io.IO_WE   = we_q;
  assign io.IO_ADDR = addr_q;
  assign io.IO_WD   = wd_q;
endmodule

// File: tb/tb_phy_mem_io.sv
// Directed bench for phy_mem_io with default parameters (RAM_DEPTH 14, 4 slots of 256 words).
module tb_phy_mem_io;
  localparam int TIMEOUT = 15;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [29:0] I_ADDR, D_ADDR;
  logic [31:0] I_DATA, D_WD, D_RD;
  logic        I_BERR, D_RE, D_WE, INHIBIT, D_BERR_A, D_BERR, D_STALL;
  logic [3:0]  D_BE;
  int          checks = 0;
  int          errors = 0;

  phy_mem_io_if #(.IO_SLOTS(4), .SLOT_DEPTH(8)) io_bus ();

  phy_mem_io #(.RAM_DEPTH(14), .IO_SLOTS(4), .SLOT_DEPTH(8), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .RESET(RESET), .I_ADDR(I_ADDR), .I_DATA(I_DATA), .I_BERR(I_BERR),
    .D_ADDR(D_ADDR), .D_RE(D_RE), .D_WE(D_WE), .D_BE(D_BE), .D_WD(D_WD),
    .INHIBIT(INHIBIT), .D_RD(D_RD), .D_BERR_A(D_BERR_A), .D_BERR(D_BERR),
    .D_STALL(D_STALL), .io(io_bus)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK); #1;
  endtask

  task automatic test_reset();
    RESET = 1'b1; D_ADDR = 30'h4205; D_RE = 1'b1; I_ADDR = 30'h8000;
    step(); step();
    checks++; if (D_STALL !== 1'b0) begin errors++; $display("FAIL rst_stall: got %b want 0", D_STALL); end
    checks++; if (io_bus.IO_REQ !== 4'b0000) begin errors++; $display("FAIL rst_ioreq: got %b want 0000", io_bus.IO_REQ); end
    checks++; if (I_BERR !== 1'b0) begin errors++; $display("FAIL rst_iberr: got %b want 0", I_BERR); end
    checks++; if (D_BERR !== 1'b0) begin errors++; $display("FAIL rst_dberr: got %b want 0", D_BERR); end
    RESET = 1'b0; D_RE = 1'b0; I_ADDR = '0;
    step();
  endtask

  task automatic test_ram();
    step(); D_ADDR = 30'h10; D_WE = 1'b1; D_BE = 4'hF; D_WD = 32'h0;
    step(); D_BE = 4'b0011; D_WD = 32'hDEADBEEF; #1;
    checks++; if (D_STALL !== 1'b0) begin errors++; $display("FAIL ram_wr_stall: got %b want 0", D_STALL); end
    step(); D_ADDR = 30'h11; D_BE = 4'hF; D_WD = 32'h12345678;
    step(); D_BE = 4'b1010; D_WD = 32'hAABBCCDD;
    step(); D_WE = 1'b0; D_RE = 1'b1; D_ADDR = 30'h10; #1;
    checks++; if (D_STALL !== 1'b0) begin errors++; $display("FAIL ram_rd_stall: got %b want 0", D_STALL); end
    step(); D_ADDR = 30'h11; I_ADDR = 30'h11;
    checks++; if (D_RD !== 32'h0000BEEF) begin errors++; $display("FAIL ram_rd_lo: got %h want 0000beef", D_RD); end
    step(); D_RE = 1'b0; I_ADDR = '0;
    checks++; if (D_RD !== 32'hAA34CC78) begin errors++; $display("FAIL ram_rd_be: got %h want aa34cc78", D_RD); end
    checks++; if (I_DATA !== 32'hAA34CC78) begin errors++; $display("FAIL ram_ifetch: got %h want aa34cc78", I_DATA); end
  endtask

  // Slot 2, offset 5; a stray ack from slot 0 in the first WAIT cycle must be ignored.
  task automatic test_io_read();
    int n = 0;
    step(); D_ADDR = 30'h4205; D_RE = 1'b1; #1;
    checks++; if (D_STALL !== 1'b1) begin errors++; $display("FAIL ior_stall_idle: got %b want 1", D_STALL); end
    for (int i = 0; i < 3; i++) begin
      step();
      if (io_bus.IO_REQ === 4'b0100) n++;
      if (i == 0) begin
        checks++; if (io_bus.IO_ADDR !== 8'd5) begin errors++; $display("FAIL ior_addr: got %h want 05", io_bus.IO_ADDR); end
        checks++; if (io_bus.IO_WE !== 1'b0) begin errors++; $display("FAIL ior_we: got %b want 0", io_bus.IO_WE); end
        io_bus.IO_ACK = 4'b0001;
      end else if (i == 1) begin
        checks++; if (D_STALL !== 1'b1) begin errors++; $display("FAIL ior_stall_wait: got %b want 1", D_STALL); end
        io_bus.IO_ACK = 4'b0000;
      end else begin
        io_bus.IO_RD[2] = 32'h12345678; io_bus.IO_ACK = 4'b0100;
      end
    end
    step();
    checks++; if (n != 3) begin errors++; $display("FAIL ior_req_cycles: got %0d want 3", n); end
    checks++; if (io_bus.IO_REQ !== 4'b0000) begin errors++; $display("FAIL ior_req_drop: got %b want 0000", io_bus.IO_REQ); end
    checks++; if (D_STALL !== 1'b0) begin errors++; $display("FAIL ior_stall_done: got %b want 0", D_STALL); end
    io_bus.IO_ACK = 4'b0000; D_RE = 1'b0;
    step();
    checks++; if (D_RD !== 32'h12345678) begin errors++; $display("FAIL ior_rd: got %h want 12345678", D_RD); end
    checks++; if (D_BERR !== 1'b0) begin errors++; $display("FAIL ior_berr: got %b want 0", D_BERR); end
  endtask

  // Counter is 0 in the first WAIT cycle, so the strobe stays up TIMEOUT+1 cycles.
  task automatic test_io_timeout();
    int n = 0;
    step(); D_ADDR = 30'h413C; D_WE = 1'b1; D_BE = 4'hF; D_WD = 32'hCAFEF00D;
    step();
    checks++; if (io_bus.IO_WD !== 32'hCAFEF00D) begin errors++; $display("FAIL iot_wd: got %h want cafef00d", io_bus.IO_WD); end
    checks++; if (io_bus.IO_WE !== 1'b1) begin errors++; $display("FAIL iot_we: got %b want 1", io_bus.IO_WE); end
    while (io_bus.IO_REQ === 4'b0010 && n < 40) begin n++; step(); end
    checks++; if (n != TIMEOUT + 1) begin errors++; $display("FAIL iot_req_cycles: got %0d want %0d", n, TIMEOUT + 1); end
    checks++; if (D_STALL !== 1'b0) begin errors++; $display("FAIL iot_stall_done: got %b want 0", D_STALL); end
    D_WE = 1'b0;
    step();
    checks++; if (D_BERR !== 1'b1) begin errors++; $display("FAIL iot_berr: got %b want 1", D_BERR); end
    checks++; if (D_RD !== 32'h0) begin errors++; $display("FAIL iot_rd: got %h want 00000000", D_RD); end
    step();
    checks++; if (D_BERR !== 1'b0) begin errors++; $display("FAIL iot_berr_clear: got %b want 0", D_BERR); end
  endtask

  // Ack arriving in the very cycle the counter hits TIMEOUT completes normally.
  task automatic test_ack_wins_timeout();
    int n = 0;
    step(); D_ADDR = 30'h4307; D_RE = 1'b1;
    for (int i = 0; i <= TIMEOUT; i++) begin
      step();
      if (io_bus.IO_REQ === 4'b1000) n++;
    end
    io_bus.IO_RD[3] = 32'hA5A5A5A5; io_bus.IO_ACK = 4'b1000;
    step(); io_bus.IO_ACK = 4'b0000; D_RE = 1'b0;
    checks++; if (n != TIMEOUT + 1) begin errors++; $display("FAIL awt_req_cycles: got %0d want %0d", n, TIMEOUT + 1); end
    step();
    checks++; if (D_RD !== 32'hA5A5A5A5) begin errors++; $display("FAIL awt_rd: got %h want a5a5a5a5", D_RD); end
    checks++; if (D_BERR !== 1'b0) begin errors++; $display("FAIL awt_berr: got %b want 0", D_BERR); end
  endtask

  task automatic test_reserved();
    step(); D_ADDR = 30'h8000; D_RE = 1'b1; I_ADDR = 30'h8000; #1;
    checks++; if (D_BERR_A !== 1'b1) begin errors++; $display("FAIL rsv_berra: got %b want 1", D_BERR_A); end
    checks++; if (D_STALL !== 1'b0) begin errors++; $display("FAIL rsv_stall: got %b want 0", D_STALL); end
    step();
    checks++; if (D_BERR !== 1'b1) begin errors++; $display("FAIL rsv_dberr: got %b want 1", D_BERR); end
    checks++; if (I_BERR !== 1'b1) begin errors++; $display("FAIL rsv_iberr: got %b want 1", I_BERR); end
    D_ADDR = 30'h4400; I_ADDR = '0; #1;
    checks++; if (D_BERR_A !== 1'b1) begin errors++; $display("FAIL rsv_gap_berra: got %b want 1", D_BERR_A); end
    checks++; if (D_STALL !== 1'b0) begin errors++; $display("FAIL rsv_gap_stall: got %b want 0", D_STALL); end
    step(); D_RE = 1'b0; #1;
    checks++; if (D_BERR_A !== 1'b0) begin errors++; $display("FAIL rsv_noreq_berra: got %b want 0", D_BERR_A); end
    step();
    checks++; if (D_BERR !== 1'b0) begin errors++; $display("FAIL rsv_dberr_clear: got %b want 0", D_BERR); end
    checks++; if (I_BERR !== 1'b0) begin errors++; $display("FAIL rsv_iberr_clear: got %b want 0", I_BERR); end
  endtask

  task automatic test_reset_mid_wait();
    step(); D_ADDR = 30'h4000; D_RE = 1'b1;
    step(); step(); RESET = 1'b1; #1;
    checks++; if (D_STALL !== 1'b0) begin errors++; $display("FAIL rmw_stall_in_rst: got %b want 0", D_STALL); end
    step(); RESET = 1'b0; D_RE = 1'b0; #1;
    checks++; if (io_bus.IO_REQ !== 4'b0000) begin errors++; $display("FAIL rmw_ioreq: got %b want 0000", io_bus.IO_REQ); end
    checks++; if (D_STALL !== 1'b0) begin errors++; $display("FAIL rmw_stall: got %b want 0", D_STALL); end
    step();
    checks++; if (io_bus.IO_REQ !== 4'b0000) begin errors++; $display("FAIL rmw_ioreq_idle: got %b want 0000", io_bus.IO_REQ); end
  endtask

  task automatic test_inhibit();
    step(); D_ADDR = 30'h20; D_WE = 1'b1; D_BE = 4'hF; D_WD = 32'h11111111;
    step(); D_WD = 32'h22222222; INHIBIT = 1'b1;
    step(); D_ADDR = 30'h4205; D_WD = 32'h33333333; #1;
    checks++; if (D_STALL !== 1'b0) begin errors++; $display("FAIL inh_stall: got %b want 0", D_STALL); end
    step(); D_WE = 1'b0; INHIBIT = 1'b0; D_ADDR = 30'h20; D_RE = 1'b1;
    checks++; if (io_bus.IO_REQ !== 4'b0000) begin errors++; $display("FAIL inh_ioreq: got %b want 0000", io_bus.IO_REQ); end
    step(); D_RE = 1'b0;
    checks++; if (D_RD !== 32'h11111111) begin errors++; $display("FAIL inh_ram: got %h want 11111111", D_RD); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET = 1'b1; I_ADDR = '0; D_ADDR = '0; D_RE = 1'b0; D_WE = 1'b0; D_BE = '0;
    D_WD = '0; INHIBIT = 1'b0; io_bus.IO_ACK = '0; io_bus.IO_RD = '0;
    test_reset();
    test_ram();
    test_io_read();
    test_io_timeout();
    test_ack_wins_timeout();
    test_reserved();
    test_reset_mid_wait();
    test_inhibit();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
